// File: rtl/pwm_bank.sv
// pwm_bank -- CHANNELS PWM outputs sharing one free-running period counter.
// Define PWM_BANK_FADE_EN to step active duties by 1 per period toward pending.
module pwm_bank #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                wr_en,
    input  logic [CW-1:0]       wr_chan,
    input  logic [WIDTH-1:0]    wr_data,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_start,
    output logic [CHANNELS-1:0] busy
);

    // Last count value; a period is 2^WIDTH-1 cycles so full duty stays high.
    localparam logic [WIDTH-1:0] MAX = {{(WIDTH-1){1'b1}}, 1'b0};

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] pending [CHANNELS];
    logic [WIDTH-1:0] active  [CHANNELS];
    logic             boundary;

    assign boundary = enable && (count == MAX);

    // Shared period counter and first-cycle marker.
    always_ff @(posedge clk) begin
        if (reset) begin
            count        <= '0;
            period_start <= 1'b0;
        end else begin
            period_start <= enable && (count == '0);
            if (enable) begin
                if (count == MAX)
                    count <= '0;
                else
                    count <= count + WIDTH'(1);
            end
        end
    end

    // Host-side pending duties; out-of-range channels match nothing.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++)
                pending[i] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < CHANNELS; i++)
                if (wr_chan == CW'(i))
                    pending[i] <= wr_data;
        end
    end

    // Active duties change only at the period boundary, from pre-write pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++)
                active[i] <= '0;
        end else if (boundary) begin
            for (int i = 0; i < CHANNELS; i++) begin
`ifdef PWM_BANK_FADE_EN
                if (active[i] < pending[i])
                    active[i] <= active[i] + WIDTH'(1);
                else if (active[i] > pending[i])
                    active[i] <= active[i] - WIDTH'(1);
`else
                active[i] <= pending[i];
`endif
            end
        end
    end

    // Registered compare outputs and pending-vs-active status.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_out <= '0;
            busy    <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                busy[i] <= (active[i] != pending[i]);
                if (enable)
                    pwm_out[i] <= (count < active[i]);
            end
        end
    end

endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank -- vector table, directed period checks and a
// randomized run against a period-position reference model.
module tb_pwm_bank;

    localparam int CH  = 4;
    localparam int W   = 8;
    localparam int PER = 255;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic         wr_en = 1'b0;
    logic [1:0]   wr_chan = '0;
    logic [W-1:0] wr_data = '0;
    logic [CH-1:0] pwm_out;
    logic          period_start;
    logic [CH-1:0] busy;

    pwm_bank #(.CHANNELS(CH), .WIDTH(W)) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .wr_en(wr_en),
        .wr_chan(wr_chan),
        .wr_data(wr_data),
        .pwm_out(pwm_out),
        .period_start(period_start),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nerr = 0;

    // Reference model: n = enabled cycles since reset, position = n mod PER.
    int n;
    int pend [CH];
    int act  [CH];
    logic [CH-1:0] e_pwm;
    logic          e_ps;
    logic [CH-1:0] e_busy;

    int  hi_cnt [CH];
    bit  order_ok [CH];
    int  plen;

    task automatic model_edge();
        int pos;
        if (reset) begin
            n = 0;
            for (int i = 0; i < CH; i++) begin
                pend[i] = 0;
                act[i] = 0;
            end
            e_pwm = '0;
            e_ps = 1'b0;
            e_busy = '0;
        end else begin
            for (int i = 0; i < CH; i++)
                e_busy[i] = (act[i] != pend[i]);
            if (enable) begin
                pos = n % PER;
                for (int i = 0; i < CH; i++)
                    e_pwm[i] = (pos < act[i]);
                e_ps = (pos == 0);
                n++;
                if (n % PER == 0) begin
                    for (int i = 0; i < CH; i++) begin
`ifdef PWM_BANK_FADE_EN
                        if (act[i] < pend[i]) act[i]++;
                        else if (act[i] > pend[i]) act[i]--;
`else
                        act[i] = pend[i];
`endif
                    end
                end
            end else begin
                e_ps = 1'b0;
            end
            if (wr_en && int'(wr_chan) < CH)
                pend[wr_chan] = int'(wr_data);
        end
    endtask

    task automatic chk(input string name, input int got, input int exp);
        ncmp++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // One clock edge, model update, then compare all outputs.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        ncmp++;
        if (pwm_out !== e_pwm || period_start !== e_ps || busy !== e_busy) begin
            nerr++;
            if (nerr < 30)
                $display("FAIL model t=%0t: pwm=%b ps=%b busy=%b expected %b %b %b",
                         $time, pwm_out, period_start, busy, e_pwm, e_ps, e_busy);
        end
    endtask

    task automatic wait_ps();
        int k = 0;
        while (!period_start && k < 600) begin
            tick();
            k++;
        end
        if (!period_start)
            chk("wait_period_start timeout", 0, 1);
    endtask

    // Called on a period_start sample; walks to the next one.
    task automatic period_stats();
        bit seen_low [CH];
        for (int i = 0; i < CH; i++) begin
            hi_cnt[i] = 0;
            order_ok[i] = 1'b1;
            seen_low[i] = 1'b0;
        end
        plen = 0;
        do begin
            for (int i = 0; i < CH; i++) begin
                if (pwm_out[i]) begin
                    hi_cnt[i]++;
                    if (seen_low[i]) order_ok[i] = 1'b0;
                end else begin
                    seen_low[i] = 1'b1;
                end
            end
            plen++;
            tick();
        end while (!period_start && plen < 600);
    endtask

    task automatic write(input int ch, input int d);
        wr_en = 1'b1;
        wr_chan = 2'(ch);
        wr_data = W'(d);
        tick();
        wr_en = 1'b0;
    endtask

    typedef struct {
        logic          rst;
        logic          en;
        logic          we;
        logic [1:0]    ch;
        logic [W-1:0]  d;
        logic [CH-1:0] pwm;
        logic          ps;
        logic [CH-1:0] bsy;
    } vec_t;

    vec_t tbl [8];

    initial begin
        logic [CH-1:0] held;
        bit ok;
        int k;

        tbl[0] = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0,   4'b0000, 1'b0, 4'b0000};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 2'd2, 8'd64,  4'b0000, 1'b0, 4'b0000};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 2'd0, 8'd0,   4'b0000, 1'b0, 4'b0000};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 2'd2, 8'd64,  4'b0000, 1'b0, 4'b0000};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 2'd0, 8'd0,   4'b0000, 1'b0, 4'b0100};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 2'd1, 8'd255, 4'b0000, 1'b1, 4'b0100};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 2'd0, 8'd0,   4'b0000, 1'b0, 4'b0110};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 2'd0, 8'd0,   4'b0000, 1'b0, 4'b0110};

        for (int v = 0; v < 8; v++) begin
            reset = tbl[v].rst;
            enable = tbl[v].en;
            wr_en = tbl[v].we;
            wr_chan = tbl[v].ch;
            wr_data = tbl[v].d;
            tick();
            chk($sformatf("vec%0d pwm", v), int'(pwm_out), int'(tbl[v].pwm));
            chk($sformatf("vec%0d ps", v), int'(period_start), int'(tbl[v].ps));
            chk($sformatf("vec%0d busy", v), int'(busy), int'(tbl[v].bsy));
        end
        wr_en = 1'b0;

`ifndef PWM_BANK_FADE_EN
        // ch0=0, ch1=255, ch2=64 over three full periods.
        wait_ps();
        for (int p = 0; p < 3; p++) begin
            period_stats();
            chk($sformatf("p%0d len", p), plen, PER);
            chk($sformatf("p%0d ch0 hi", p), hi_cnt[0], 0);
            chk($sformatf("p%0d ch1 hi", p), hi_cnt[1], PER);
            chk($sformatf("p%0d ch2 hi", p), hi_cnt[2], 64);
            chk($sformatf("p%0d ch2 order", p), int'(order_ok[2]), 1);
        end

        // Mid-period write to ch0 at count 50 waits for the boundary.
        repeat (50) tick();
        write(0, 100);
        tick();
        chk("ch0 busy after write", int'(busy[0]), 1);
        ok = 1'b1;
        k = 0;
        while (!period_start && k < 600) begin
            if (!busy[0] || pwm_out[0]) ok = 1'b0;
            tick();
            k++;
        end
        chk("ch0 held until boundary", int'(ok), 1);
        period_stats();
        chk("ch0 new duty hi", hi_cnt[0], 100);
        chk("ch0 new duty order", int'(order_ok[0]), 1);
        chk("ch0 busy cleared", int'(busy[0]), 0);

        // Ten stalled cycles stretch one period to 265.
        plen = 0;
        repeat (30) begin tick(); plen++; end
        held = pwm_out;
        ok = 1'b1;
        enable = 1'b0;
        repeat (10) begin
            tick();
            plen++;
            if (pwm_out !== held || period_start) ok = 1'b0;
        end
        enable = 1'b1;
        while (!period_start && plen < 600) begin tick(); plen++; end
        chk("stall frozen", int'(ok), 1);
        chk("stall period len", plen, PER + 10);

        // Reset at count 120 with every duty nonzero.
        write(3, 30);
        wait_ps();
        period_stats();
        chk("ch3 hi before reset", hi_cnt[3], 30);
        repeat (119) tick();
        reset = 1'b1;
        tick();
        chk("rst pwm", int'(pwm_out), 0);
        chk("rst ps", int'(period_start), 0);
        chk("rst busy", int'(busy), 0);
        reset = 1'b0;
        tick();
        chk("post-rst restart ps", int'(period_start), 1);
        ok = 1'b1;
        repeat (300) begin
            tick();
            if (pwm_out != 0 || busy != 0) ok = 1'b0;
        end
        chk("post-rst outputs stay 0", int'(ok), 1);
`endif

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            reset = ($urandom_range(0, 1499) == 0);
            enable = ($urandom_range(0, 7) != 0);
            wr_en = ($urandom_range(0, 5) == 0);
            wr_chan = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: wr_data = '0;
                1: wr_data = '1;
                default: wr_data = W'($urandom);
            endcase
            tick();
        end
        reset = 1'b0;
        wr_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
